// File: rtl/rf_wb_arbiter.sv
// Register-file write-port front end: merges the priority ALU stream (A) with a
// FIFO-buffered variable-latency stream (B), with WAW squash and pending-write flags.

module rf_wb_entry #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic              clr,
  input  logic              sq,
  input  logic [ADDR_W-1:0] sq_addr,
  input  logic [ADDR_W-1:0] wr_in,
  input  logic [DATA_W-1:0] wd_in,
  output logic              vld,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] wd
);
  // Load wins over squash: only the free tail slot is ever loaded, so the two never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      wr  <= '0;
      wd  <= '0;
    end else if (ld) begin
      vld <= 1'b1;
      wr  <= wr_in;
      wd  <= wd_in;
    end else if (clr || (sq && wr == sq_addr)) begin
      vld <= 1'b0;
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_a,
  input  logic [ADDR_W-1:0] WR_a,
  input  logic [DATA_W-1:0] WD_a,
  input  logic              valid_b,
  input  logic [ADDR_W-1:0] WR_b,
  input  logic [DATA_W-1:0] WD_b,
  output logic              ready_b,
  input  logic [ADDR_W-1:0] PR1,
  input  logic [ADDR_W-1:0] PR2,
  output logic              pend1,
  output logic              pend2,
  output logic              write,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

  wb_req_t req_a, req_b, head_req;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_wr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_wd;

  logic acc_b, empty, pop, bypass, push, squash;

  assign req_a    = '{wr: WR_a, wd: WD_a};
  assign req_b    = '{wr: WR_b, wd: WD_b};
  assign head_req = '{wr: ent_wr[head], wd: ent_wd[head]};

  // Gated by reset so the producer sees no room while the block is held in reset.
  assign ready_b = reset && (count < CW'(DEPTH));
  assign acc_b   = valid_b && ready_b;
  assign empty   = (count == '0);
  assign squash  = write_a && (WR_a != '0);
  assign pop     = !write_a && !empty;
  assign bypass  = !write_a && empty && acc_b && (WR_b != '0);
  assign push    = acc_b && !bypass && (WR_b != '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rf_wb_entry #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .ld      (push && tail == PW'(g)),
      .clr     (pop && head == PW'(g)),
      .sq      (squash),
      .sq_addr (WR_a),
      .wr_in   (WR_b),
      .wd_in   (WD_b),
      .vld     (ent_vld[g]),
      .wr      (ent_wr[g]),
      .wd      (ent_wd[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // A squashed head still consumes its slot, but as a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write <= 1'b0;
      WR    <= '0;
      WD    <= '0;
    end else if (write_a) begin
      write <= (WR_a != '0);
      WR    <= req_a.wr;
      WD    <= req_a.wd;
    end else if (pop) begin
      write <= ent_vld[head];
      WR    <= head_req.wr;
      WD    <= head_req.wd;
    end else if (bypass) begin
      write <= 1'b1;
      WR    <= req_b.wr;
      WD    <= req_b.wd;
    end else begin
      write <= 1'b0;
    end
  end

  logic hit1, hit2;
  always_comb begin
    hit1 = write && (WR == PR1);
    hit2 = write && (WR == PR2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_wr[i] == PR1) hit1 = 1'b1;
      if (ent_vld[i] && ent_wr[i] == PR2) hit2 = 1'b1;
    end
  end

  assign pend1 = (PR1 != '0) && hit1;
  assign pend2 = (PR2 != '0) && hit2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, async-reset sequence, and
// randomized traffic against a queue-based reference model.

module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_a = 1'b0;
  logic [4:0]  WR_a = '0;
  logic [31:0] WD_a = '0;
  logic        valid_b = 1'b0;
  logic [4:0]  WR_b = '0;
  logic [31:0] WD_b = '0;
  logic        ready_b;
  logic [4:0]  PR1 = '0;
  logic [4:0]  PR2 = '0;
  logic        pend1, pend2;
  logic        write;
  logic [4:0]  WR;
  logic [31:0] WD;

  rf_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .write_a(write_a), .WR_a(WR_a), .WD_a(WD_a),
    .valid_b(valid_b), .WR_b(WR_b), .WD_b(WD_b), .ready_b(ready_b),
    .PR1(PR1), .PR2(PR2), .pend1(pend1), .pend2(pend2),
    .write(write), .WR(WR), .WD(WD)
  );

  always #5 clk = ~clk;

  // Register file model: commits the presented slot at each rising edge.
  logic [31:0] rf [32];
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    forever begin
      @(posedge clk);
      if (write) rf[WR] = WD;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wa;
    logic [4:0]  wra;
    logic [31:0] wda;
    logic        vb;
    logic [4:0]  wrb;
    logic [31:0] wdb;
    logic [4:0]  pr1;
    logic        e_ready;
    logic        e_write;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_pend1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wa, logic [4:0] wra, logic [31:0] wda,
                              logic vb, logic [4:0] wrb, logic [31:0] wdb, logic [4:0] pr1,
                              logic er, logic ew, logic [4:0] ewr, logic [31:0] ewd, logic ep);
    vec_t v;
    v.wa = wa; v.wra = wra; v.wda = wda; v.vb = vb; v.wrb = wrb; v.wdb = wdb; v.pr1 = pr1;
    v.e_ready = er; v.e_write = ew; v.e_wr = ewr; v.e_wd = ewd; v.e_pend1 = ep;
    return v;
  endfunction

  // Expectations are the post-edge values of outputs and pend flags.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      write_a = tbl[i].wa; WR_a = tbl[i].wra; WD_a = tbl[i].wda;
      valid_b = tbl[i].vb; WR_b = tbl[i].wrb; WD_b = tbl[i].wdb;
      PR1 = tbl[i].pr1; PR2 = '0;
      @(posedge clk); #1;
      chk($sformatf("row%0d.ready", i), 32'(ready_b), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d.write", i), 32'(write), 32'(tbl[i].e_write));
      if (tbl[i].e_write) begin
        chk($sformatf("row%0d.WR", i), 32'(WR), 32'(tbl[i].e_wr));
        chk($sformatf("row%0d.WD", i), WD, tbl[i].e_wd);
      end
      chk($sformatf("row%0d.pend1", i), 32'(pend1), 32'(tbl[i].e_pend1));
      chk($sformatf("row%0d.pend2", i), 32'(pend2), 32'(0));
    end
    @(negedge clk);
    write_a = 0; valid_b = 0;
  endtask

  typedef struct { logic v; logic [4:0] wr; logic [31:0] wd; } ment_t;
  ment_t       m_q[$];
  logic        m_w;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  function automatic logic m_pend(logic [4:0] pr);
    logic h;
    h = m_w && (m_wr == pr);
    foreach (m_q[i]) if (m_q[i].v && m_q[i].wr == pr) h = 1'b1;
    return (pr != 0) && h;
  endfunction

  initial begin
    // 0..1: A write to reg 4; 2..3: bypass B
    tbl.push_back(mk(1, 4, 31,    0, 0, 0,      4, 1, 1, 4, 31,   1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,      4, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,     1, 10, 100,   10, 1, 1, 10, 100, 1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,      10, 1, 0, 0, 0,   0));
    // 4..14: A burst to regs 1..6 while B offers 20..25
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mk(1, 5'(k), 32'h100 + 32'(k), 1, 5'(19 + k), 32'(199 + k), 22,
                       (k < 4), 1, 5'(k), 32'h100 + 32'(k), (k >= 3)));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 22, 1, 1, 5'(20 + k), 32'(200 + k), (k <= 2)));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,      22, 1, 0, 0, 0,   0));
    // 15..17: WAW squash on reg 7
    tbl.push_back(mk(1, 1, 10,    1, 7, 70,     7, 1, 1, 1, 10,   1));
    tbl.push_back(mk(1, 7, 77,    0, 0, 0,      7, 1, 1, 7, 77,   1));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,      7, 1, 0, 0, 0,    0));
    // 18..19: register 0
    tbl.push_back(mk(1, 0, 5,     1, 0, 9,      0, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,      0, 1, 0, 0, 0,    0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.write", 32'(write), 0);
    chk("rst.WR", 32'(WR), 0);
    chk("rst.WD", WD, 0);
    chk("rst.ready", 32'(ready_b), 0);
    chk("rst.pend1", 32'(pend1), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel.ready", 32'(ready_b), 1);

    run_rows(0, 1);
    chk("rf4", rf[4], 31);
    chk("rf6", rf[6], 6);
    run_rows(2, 3);
    run_rows(4, 14);
    run_rows(15, 17);
    chk("rf7", rf[7], 77);
    run_rows(18, 19);
    chk("rf0", rf[0], 0);

    // Async reset with 3 buffered entries and a presented write
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      write_a = 1; WR_a = 5'(14 + k); WD_a = 32'hE0 + 32'(k);
      valid_b = 1; WR_b = 5'(17 + k); WD_b = 32'h170 + 32'(k);
    end
    @(posedge clk); #1;
    chk("pre_rst.write", 32'(write), 1);
    chk("pre_rst.ready", 32'(ready_b), 1);
    #2;
    write_a = 0; valid_b = 0; PR1 = 17; PR2 = 16;
    reset = 1'b0;
    #1;
    chk("async.write", 32'(write), 0);
    chk("async.WR", 32'(WR), 0);
    chk("async.WD", WD, 0);
    chk("async.ready", 32'(ready_b), 0);
    chk("async.pend1", 32'(pend1), 0);
    chk("async.pend2", 32'(pend2), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel2.ready", 32'(ready_b), 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d.write", k), 32'(write), 0);
    end
    chk("rf14", rf[14], 32'hE0);
    chk("rf16", rf[16], 16);
    for (int k = 17; k <= 19; k++) chk($sformatf("rf%0d", k), rf[k], 32'(k));

    // Randomized traffic against the queue model
    m_q.delete();
    m_w = 0; m_wr = 0; m_wd = 0;
    for (int c = 0; c < 400; c++) begin
      logic exp_ready, acc, byp;
      ment_t e;
      @(negedge clk);
      write_a = ($urandom_range(0, 99) < 40);
      WR_a    = 5'($urandom_range(0, 7));
      WD_a    = $urandom;
      valid_b = ($urandom_range(0, 99) < 60);
      WR_b    = 5'($urandom_range(0, 7));
      WD_b    = $urandom;
      PR1     = 5'($urandom_range(0, 7));
      PR2     = 5'($urandom_range(0, 7));
      #1;
      exp_ready = (m_q.size() < DEPTH);
      chk("rnd.ready", 32'(ready_b), 32'(exp_ready));
      chk("rnd.pend1", 32'(pend1), 32'(m_pend(PR1)));
      chk("rnd.pend2", 32'(pend2), 32'(m_pend(PR2)));
      @(posedge clk);
      acc = valid_b && exp_ready;
      byp = 0;
      if (write_a) begin
        if (WR_a != 0) foreach (m_q[i]) if (m_q[i].wr == WR_a) m_q[i].v = 0;
        m_w = (WR_a != 0); m_wr = WR_a; m_wd = WD_a;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_w = e.v; m_wr = e.wr; m_wd = e.wd;
      end else if (acc && WR_b != 0) begin
        m_w = 1; m_wr = WR_b; m_wd = WD_b; byp = 1;
      end else begin
        m_w = 0;
      end
      if (acc && !byp && WR_b != 0) begin
        e.v = 1; e.wr = WR_b; e.wd = WD_b;
        m_q.push_back(e);
      end
      #1;
      chk("rnd.write", 32'(write), 32'(m_w));
      if (m_w) begin
        chk("rnd.WR", 32'(WR), 32'(m_wr));
        chk("rnd.WD", WD, m_wd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
